// File: rtl/sysinfo_csr.sv
// sysinfo_csr: Avalon-MM system information block (ID, build timestamp,
// 64-bit cycle counter with HI snapshot, overflow interrupt, scratch registers).
module sysinfo_csr #(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1363010471,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned NUM_SCRATCH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_ID       = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TIME     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CYCLE_LO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CYCLE_HI = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CONTROL  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(5);
  localparam int unsigned       SCRATCH_BASE = 6;

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];

  logic        rd_acc;
  logic        wr_ctrl;
  logic        clr;
  logic        wrap;
  logic        w1c_ovf;
  logic [31:0] rd_mux;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // A cycle with both strobes is handled purely as a write.
  always_comb begin
    rd_acc  = read & ~write;
    wr_ctrl = write && (address == A_CONTROL) && byteenable[0];
    clr     = wr_ctrl && writedata[1];
    w1c_ovf = write && (address == A_STATUS) && byteenable[0] && writedata[0];
    wrap    = ~clr && en_q && (cnt_q == '1);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_ID:       rd_mux = SYSTEM_ID;
      A_TIME:     rd_mux = TIMESTAMP;
      A_CYCLE_LO: rd_mux = cnt_q[31:0];
      A_CYCLE_HI: rd_mux = hi_q;
      A_CONTROL:  rd_mux = {29'b0, irq_en_q, 1'b0, en_q};
      A_STATUS:   rd_mux = {31'b0, ovf_q};
      default:    rd_mux = '0;
    endcase
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      if (address == ADDR_W'(SCRATCH_BASE + i)) rd_mux = scratch_q[i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (en_q) cnt_d = cnt_q + 64'd1;

    // Wrap outranks a same-cycle W1C so an overflow is never lost.
    ovf_d = ovf_q;
    if (wrap)         ovf_d = 1'b1;
    else if (w1c_ovf) ovf_d = 1'b0;

    en_d     = wr_ctrl ? writedata[0] : en_q;
    irq_en_d = wr_ctrl ? writedata[2] : irq_en_q;
    irq_d    = ovf_q & irq_en_q;

    hi_d = hi_q;
    if (rd_acc && (address == A_CYCLE_LO)) hi_d = cnt_q[63:32];

    scratch_d = scratch_q;
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      if (write && (address == ADDR_W'(SCRATCH_BASE + i)))
        scratch_d[i] = be_merge(scratch_q[i], writedata, byteenable);
    end

    readdata_d = rd_acc ? rd_mux : readdata_q;
    rdv_d      = rd_acc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      en_q       <= 1'b1;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign irq           = irq_q;

endmodule
